// File: rtl/rotate_ddr_sched_if.sv
// DDRAM write-port bundle shared between the write scheduler and the HPS DDR bridge.
interface rotate_ddr_sched_if;
    logic        DDRAM_CLK;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic        DDRAM_RD;

    // Scheduler side: drives the command, observes the stall.
    modport master (
        output DDRAM_CLK,
        input  DDRAM_BUSY,
        output DDRAM_BURSTCNT,
        output DDRAM_ADDR,
        output DDRAM_DIN,
        output DDRAM_BE,
        output DDRAM_WE,
        output DDRAM_RD
    );

    // Memory side: consumes the command, raises the stall.
    modport slave (
        input  DDRAM_CLK,
        output DDRAM_BUSY,
        input  DDRAM_BURSTCNT,
        input  DDRAM_ADDR,
        input  DDRAM_DIN,
        input  DDRAM_BE,
        input  DDRAM_WE,
        input  DDRAM_RD
    );
endinterface

// File: rtl/rotate_ddr_sched.sv
// Two-requester DDRAM write scheduler: per-requester FIFOs, round-robin grant,
// one registered command held stable until the DDR port accepts it.
module rotate_ddr_sched #(
    parameter logic [6:0] MEM_BASE = 7'b0010010,
    parameter int          DEPTH    = 8
) (
    input  logic        CLK_VIDEO,
    input  logic        reset,
    input  logic        a_wr,
    input  logic [24:0] a_addr,
    input  logic [31:0] a_data,
    output logic        a_full,
    output logic        a_ovf,
    input  logic        b_wr,
    input  logic [24:0] b_addr,
    input  logic [31:0] b_data,
    output logic        b_full,
    output logic        b_ovf,
    input  logic        ovf_clr,
    output logic        idle,
    rotate_ddr_sched_if.master ddr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // A queued command keeps only addr[24:2] (word select + qword address) and the pixel.
    typedef struct packed {
        logic [22:0] addr;
        logic [31:0] data;
    } cmd_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t      state, state_nxt;
    cmd_t        a_mem [DEPTH];
    cmd_t        b_mem [DEPTH];
    logic [PW-1:0] a_wp, a_rp, b_wp, b_rp;
    logic [CW-1:0] a_cnt, b_cnt, a_cnt_nxt, b_cnt_nxt;
    logic        a_push, b_push, a_pop, b_pop, load;
    logic        a_empty, b_empty, can_load, grant_a;
    logic        last_b;
    cmd_t        sel;
    logic [28:0] addr_q;
    logic [63:0] din_q;
    logic [7:0]  be_q;
    logic        we_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{a_addr[1:0], b_addr[1:0]};

    assign ddr.DDRAM_CLK      = CLK_VIDEO;
    assign ddr.DDRAM_BURSTCNT = 8'd1;
    assign ddr.DDRAM_RD       = 1'b0;
    assign ddr.DDRAM_ADDR     = addr_q;
    assign ddr.DDRAM_DIN      = din_q;
    assign ddr.DDRAM_BE       = be_q;
    assign ddr.DDRAM_WE       = we_q;

    // Push/pop decisions, round-robin grant and next-state; a full FIFO rejects a push even while popping.
    always_comb begin
        a_empty   = (a_cnt == '0);
        b_empty   = (b_cnt == '0);
        a_push    = a_wr & ~a_full;
        b_push    = b_wr & ~b_full;
        can_load  = (state == S_IDLE) | ~ddr.DDRAM_BUSY;
        grant_a   = (!a_empty && !b_empty) ? last_b : !a_empty;
        a_pop     = can_load & ~a_empty & grant_a;
        b_pop     = can_load & ~b_empty & ~grant_a;
        load      = a_pop | b_pop;
        sel       = grant_a ? a_mem[a_rp] : b_mem[b_rp];
        a_cnt_nxt = a_cnt + CW'(a_push) - CW'(a_pop);
        b_cnt_nxt = b_cnt + CW'(b_push) - CW'(b_pop);
        state_nxt = S_IDLE;
        if (load) begin
            state_nxt = S_ISSUE;
        end else if (state == S_ISSUE && ddr.DDRAM_BUSY) begin
            state_nxt = S_ISSUE;
        end
    end

    // FIFO storage needs no reset; only pointers and counts define validity.
    always_ff @(posedge CLK_VIDEO) begin
        if (a_push) begin
            a_mem[a_wp] <= '{addr: a_addr[24:2], data: a_data};
        end
        if (b_push) begin
            b_mem[b_wp] <= '{addr: b_addr[24:2], data: b_data};
        end
    end

    // FIFO pointers, counts, full flags and sticky overflow flags (a set beats a same-cycle clear).
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            a_wp   <= '0;
            a_rp   <= '0;
            b_wp   <= '0;
            b_rp   <= '0;
            a_cnt  <= '0;
            b_cnt  <= '0;
            a_full <= 1'b0;
            b_full <= 1'b0;
            a_ovf  <= 1'b0;
            b_ovf  <= 1'b0;
        end else begin
            if (a_push) a_wp <= a_wp + PW'(1);
            if (a_pop)  a_rp <= a_rp + PW'(1);
            if (b_push) b_wp <= b_wp + PW'(1);
            if (b_pop)  b_rp <= b_rp + PW'(1);
            a_cnt  <= a_cnt_nxt;
            b_cnt  <= b_cnt_nxt;
            a_full <= (a_cnt_nxt == FULL_CNT);
            b_full <= (b_cnt_nxt == FULL_CNT);
            if (a_wr && a_full) begin
                a_ovf <= 1'b1;
            end else if (ovf_clr) begin
                a_ovf <= 1'b0;
            end
            if (b_wr && b_full) begin
                b_ovf <= 1'b1;
            end else if (ovf_clr) begin
                b_ovf <= 1'b0;
            end
        end
    end

    // Issue FSM: loads the output command on a pop and holds it untouched while the port stalls.
    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            we_q   <= 1'b0;
            addr_q <= {MEM_BASE, 22'd0};
            din_q  <= '0;
            be_q   <= '0;
            last_b <= 1'b1;
            idle   <= 1'b1;
        end else begin
            state <= state_nxt;
            we_q  <= (state_nxt == S_ISSUE);
            idle  <= (a_cnt_nxt == '0) && (b_cnt_nxt == '0) && (state_nxt == S_IDLE);
            if (load) begin
                addr_q <= {MEM_BASE, sel.addr[22:1]};
                din_q  <= {sel.data, sel.data};
                be_q   <= sel.addr[0] ? 8'hF0 : 8'h0F;
                last_b <= b_pop;
            end
        end
    end

endmodule

// File: tb/tb_rotate_ddr_sched.sv
// Self-checking bench for rotate_ddr_sched: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_rotate_ddr_sched;

    localparam int         DEPTH    = 8;
    localparam logic [6:0] MEM_BASE = 7'b0010010;
    localparam logic [28:0] RST_ADDR = {MEM_BASE, 22'd0};

    logic        CLK_VIDEO = 1'b0;
    logic        reset;
    logic        a_wr, b_wr, ovf_clr;
    logic [24:0] a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_full, a_ovf, b_full, b_ovf, idle;

    rotate_ddr_sched_if ddr ();

    rotate_ddr_sched #(.MEM_BASE(MEM_BASE), .DEPTH(DEPTH)) dut (
        .CLK_VIDEO (CLK_VIDEO),
        .reset     (reset),
        .a_wr      (a_wr),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_full    (a_full),
        .a_ovf     (a_ovf),
        .b_wr      (b_wr),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_full    (b_full),
        .b_ovf     (b_ovf),
        .ovf_clr   (ovf_clr),
        .idle      (idle),
        .ddr       (ddr)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    typedef struct packed {
        logic [24:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } wr_t;

    typedef struct {
        logic        a_wr;
        logic [24:0] a_addr;
        logic [31:0] a_data;
        logic        b_wr;
        logic [24:0] b_addr;
        logic [31:0] b_data;
        logic        busy;
        logic        e_we;
        logic [28:0] e_addr;
        logic [63:0] e_din;
        logic [7:0]  e_be;
        logic        e_idle;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    req_t mq_a[$];
    req_t mq_b[$];
    bit   m_valid;
    wr_t  m_cmd;
    bit   m_last_b;
    bit   m_aovf, m_bovf;
    wr_t  exp_log[$];
    wr_t  dut_log[$];
    int   dut_edge[$];

    function automatic wr_t fmt(req_t r);
        wr_t w;
        w.addr = {MEM_BASE, r.addr[24:3]};
        w.din  = {r.data, r.data};
        w.be   = r.addr[2] ? 8'hF0 : 8'h0F;
        return w;
    endfunction

    function automatic void model_reset();
        mq_a.delete();
        mq_b.delete();
        m_valid  = 1'b0;
        m_cmd    = '{addr: RST_ADDR, din: 64'd0, be: 8'd0};
        m_last_b = 1'b1;
        m_aovf   = 1'b0;
        m_bovf   = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs currently driven.
    function automatic void model_step();
        bit   afull, bfull, use_a;
        req_t r;
        afull = (mq_a.size() == DEPTH);
        bfull = (mq_b.size() == DEPTH);
        if (m_valid && !ddr.DDRAM_BUSY) begin
            exp_log.push_back(m_cmd);
            m_valid = 1'b0;
        end
        if (!m_valid && (mq_a.size() > 0 || mq_b.size() > 0)) begin
            use_a = (mq_a.size() > 0 && mq_b.size() > 0) ? m_last_b : (mq_a.size() > 0);
            if (use_a) r = mq_a.pop_front();
            else       r = mq_b.pop_front();
            m_cmd    = fmt(r);
            m_valid  = 1'b1;
            m_last_b = !use_a;
        end
        if (a_wr && !afull) mq_a.push_back('{addr: a_addr, data: a_data});
        if (b_wr && !bfull) mq_b.push_back('{addr: b_addr, data: b_data});
        if (a_wr && afull) m_aovf = 1'b1;
        else if (ovf_clr)  m_aovf = 1'b0;
        if (b_wr && bfull) m_bovf = 1'b1;
        else if (ovf_clr)  m_bovf = 1'b0;
    endfunction

    task automatic cmp(input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", what, cyc, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".we"},     64'(ddr.DDRAM_WE),   64'(m_valid));
        cmp({tag, ".addr"},   64'(ddr.DDRAM_ADDR), 64'(m_cmd.addr));
        cmp({tag, ".din"},    ddr.DDRAM_DIN,       m_cmd.din);
        cmp({tag, ".be"},     64'(ddr.DDRAM_BE),   64'(m_cmd.be));
        cmp({tag, ".a_full"}, 64'(a_full),         64'(mq_a.size() == DEPTH));
        cmp({tag, ".b_full"}, 64'(b_full),         64'(mq_b.size() == DEPTH));
        cmp({tag, ".a_ovf"},  64'(a_ovf),          64'(m_aovf));
        cmp({tag, ".b_ovf"},  64'(b_ovf),          64'(m_bovf));
        cmp({tag, ".idle"},   64'(idle),           64'(mq_a.size() == 0 && mq_b.size() == 0 && !m_valid));
    endtask

    // Record an acceptance seen on the port, advance one edge, then compare with the model.
    task automatic step(input string tag);
        if (ddr.DDRAM_WE && !ddr.DDRAM_BUSY) begin
            dut_log.push_back('{addr: ddr.DDRAM_ADDR, din: ddr.DDRAM_DIN, be: ddr.DDRAM_BE});
            dut_edge.push_back(cyc);
        end
        @(posedge CLK_VIDEO);
        model_step();
        cyc++;
        #1;
        checkOutput(tag);
    endtask

    task automatic drive(input logic aw, input logic [24:0] aa, input logic [31:0] ad,
                         input logic bw, input logic [24:0] ba, input logic [31:0] bd,
                         input logic busy, input logic clr);
        a_wr = aw; a_addr = aa; a_data = ad;
        b_wr = bw; b_addr = ba; b_data = bd;
        ddr.DDRAM_BUSY = busy;
        ovf_clr = clr;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.a_wr, v.a_addr, v.a_data, v.b_wr, v.b_addr, v.b_data, v.busy, 1'b0);
        step("table");
    endtask

    function automatic vec_t mkv(logic aw, logic [24:0] aa, logic [31:0] ad,
                                 logic bw, logic [24:0] ba, logic [31:0] bd, logic busy,
                                 logic we, logic [28:0] ea, logic [63:0] ed, logic [7:0] eb,
                                 logic ei);
        vec_t v;
        v.a_wr = aw; v.a_addr = aa; v.a_data = ad;
        v.b_wr = bw; v.b_addr = ba; v.b_data = bd;
        v.busy = busy;
        v.e_we = we; v.e_addr = ea; v.e_din = ed; v.e_be = eb; v.e_idle = ei;
        return v;
    endfunction

    initial begin
        vec_t        tbl[12];
        req_t        rr_reqs[6];
        int          base;
        int          n0;
        logic [28:0] A_ADDR = {MEM_BASE, 22'd0};
        logic [63:0] A_DIN  = 64'h0011223300112233;
        logic [28:0] B_ADDR = 29'h4B579BD;
        logic [63:0] B_DIN  = 64'hCAFEF00DCAFEF00D;

        // single write then a five-cycle stall on a B write
        tbl[0]  = mkv(1, 25'h0000004, 32'h00112233, 0, 0, 0, 0, 0, RST_ADDR, 64'd0, 8'h00, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, A_ADDR, A_DIN, 8'hF0, 0);
        tbl[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, A_ADDR, A_DIN, 8'hF0, 1);
        tbl[3]  = mkv(0, 0, 0, 1, 25'h1ABCDE8, 32'hCAFEF00D, 1, 0, A_ADDR, A_DIN, 8'hF0, 0);
        tbl[4]  = mkv(0, 0, 0, 0, 0, 0, 1, 1, B_ADDR, B_DIN, 8'h0F, 0);
        for (int i = 5; i <= 9; i++) tbl[i] = mkv(0, 0, 0, 0, 0, 0, 1, 1, B_ADDR, B_DIN, 8'h0F, 0);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, B_ADDR, B_DIN, 8'h0F, 1);
        tbl[11] = mkv(0, 0, 0, 0, 0, 0, 0, 0, B_ADDR, B_DIN, 8'h0F, 1);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        cmp("rst.we",    64'(ddr.DDRAM_WE),   64'd0);
        cmp("rst.addr",  64'(ddr.DDRAM_ADDR), 64'(RST_ADDR));
        cmp("rst.din",   ddr.DDRAM_DIN,       64'd0);
        cmp("rst.be",    64'(ddr.DDRAM_BE),   64'd0);
        cmp("rst.flags", 64'({a_full, b_full, a_ovf, b_ovf}), 64'd0);
        cmp("rst.idle",  64'(idle),           64'd1);
        cmp("rst.const", 64'({ddr.DDRAM_BURSTCNT, ddr.DDRAM_RD}), 64'({8'd1, 1'b0}));
        @(negedge CLK_VIDEO);
        @(negedge CLK_VIDEO);
        reset = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i]);
            cmp("tbl.we",   64'(ddr.DDRAM_WE),   64'(tbl[i].e_we));
            cmp("tbl.addr", 64'(ddr.DDRAM_ADDR), 64'(tbl[i].e_addr));
            cmp("tbl.din",  ddr.DDRAM_DIN,       tbl[i].e_din);
            cmp("tbl.be",   64'(ddr.DDRAM_BE),   64'(tbl[i].e_be));
            cmp("tbl.idle", 64'(idle),           64'(tbl[i].e_idle));
        end
        cmp("tbl.accepts", 64'(dut_log.size()), 64'd2);

        $display("[TB] round-robin");
        for (int i = 0; i < 3; i++) begin
            rr_reqs[2*i]   = '{addr: 25'(32'h100 + 8*i), data: 32'hA0 + 32'(i)};
            rr_reqs[2*i+1] = '{addr: 25'(32'h204 + 8*i), data: 32'hB0 + 32'(i)};
        end
        base = dut_log.size();
        for (int i = 0; i < 3; i++) begin
            drive(1, rr_reqs[2*i].addr, rr_reqs[2*i].data,
                  1, rr_reqs[2*i+1].addr, rr_reqs[2*i+1].data, 1, 0);
            step("rr.fill");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("rr.drain");
        cmp("rr.count", 64'(dut_log.size() - base), 64'd6);
        if (dut_log.size() >= base + 6) begin
            for (int i = 0; i < 6; i++) begin
                cmp("rr.order", 64'(dut_log[base+i].din[31:0]), 64'(rr_reqs[i].data));
                cmp("rr.addr",  64'(dut_log[base+i].addr), 64'({MEM_BASE, rr_reqs[i].addr[24:3]}));
            end
            cmp("rr.consecutive", 64'(dut_edge[base+5] - dut_edge[base]), 64'd5);
        end

        $display("[TB] overflow");
        base = dut_log.size();
        drive(0, 0, 0, 1, 25'h0000010, 32'h0000BEEF, 1, 0);
        step("ovf.pre");
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("ovf.pre");
        for (int i = 1; i <= 10; i++) begin
            drive(1, 25'(32'h400 + 4*i), 32'h1000 + 32'(i), 0, 0, 0, 1, 0);
            step("ovf.push");
            if (i == 7) cmp("ovf.full7", 64'(a_full), 64'd0);
            if (i == 8) begin
                cmp("ovf.full8", 64'(a_full), 64'd1);
                cmp("ovf.aovf8", 64'(a_ovf),  64'd0);
            end
            if (i == 9) cmp("ovf.aovf9", 64'(a_ovf), 64'd1);
        end
        cmp("ovf.bovf", 64'(b_ovf), 64'd0);
        drive(1, 25'h0000777, 32'h77, 0, 0, 0, 1, 1);
        step("ovf.clrset");
        cmp("ovf.clr_vs_set", 64'(a_ovf), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        step("ovf.clr");
        cmp("ovf.cleared", 64'(a_ovf), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) step("ovf.drain");
        cmp("ovf.issued", 64'(dut_log.size() - base), 64'd9);

        $display("[TB] reset mid-issue");
        for (int i = 0; i < 5; i++) begin
            drive(1, 25'(32'h800 + 4*i), 32'h5000 + 32'(i), 0, 0, 0, 1, 0);
            step("rst.fill");
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        cmp("rstmid.we",   64'(ddr.DDRAM_WE), 64'd0);
        cmp("rstmid.idle", 64'(idle),         64'd1);
        @(negedge CLK_VIDEO);
        @(negedge CLK_VIDEO);
        reset = 1'b0;
        n0 = dut_log.size();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("rstmid.after");
        cmp("rstmid.no_writes", 64'(dut_log.size() - n0), 64'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            logic busy_r;
            busy_r = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 2) == 0, 25'($urandom), $urandom,
                  $urandom_range(0, 2) == 0, 25'($urandom), $urandom,
                  busy_r, $urandom_range(0, 15) == 0);
            step("rand");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * DEPTH + 8; i++) step("rand.drain");

        cmp("log.size", 64'(dut_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++) begin
            cmp("log.addr", 64'(dut_log[i].addr), 64'(exp_log[i].addr));
            cmp("log.din",  dut_log[i].din,       exp_log[i].din);
            cmp("log.be",   64'(dut_log[i].be),   64'(exp_log[i].be));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
